// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared defaults and helpers for the UART receive FIFO
package uart_rx_fifo_pkg;
  localparam int FRAME_WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 16;
  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return v == ERR_CNT_MAX ? v : v + ERR_CNT_W'(1);
  endfunction
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-side, consumer-side and status signals of the FIFO
interface uart_rx_fifo_if import uart_rx_fifo_pkg::*; #(
  parameter int FRAME_WIDTH = FRAME_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
);
  logic rx_done;
  logic rx_err;
  logic [FRAME_WIDTH-1:0] rx_data;
  logic rd_valid;
  logic rd_ready;
  logic [FRAME_WIDTH-1:0] rd_data;
  logic rd_err;
  logic [$clog2(DEPTH):0] count;
  logic full;
  logic empty;
  logic overflow;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic clr_flags;
  modport master (
    output rx_done, rx_err, rx_data, rd_ready, clr_flags,
    input rd_valid, rd_data, rd_err, count, full, empty, overflow, err_cnt
  );
  modport slave (
    input rx_done, rx_err, rx_data, rd_ready, clr_flags,
    output rd_valid, rd_data, rd_err, count, full, empty, overflow, err_cnt
  );
endinterface

// File: rtl/uart_rx_fifo_mem.sv
// rx_fifo_mem: register array, synchronous write, asynchronous read
module rx_fifo_mem #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through FIFO buffering UART frames with error tracking
module uart_rx_fifo import uart_rx_fifo_pkg::*; #(
  parameter int FRAME_WIDTH = FRAME_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DROP_ERR = 0
) (
  input logic clk,
  input logic rst,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic armed, wr_ev, keep, rd, do_wr, ovf;
  logic [ERR_CNT_W-1:0] ecnt;
  logic [FRAME_WIDTH:0] head;
  // armed means rx_done was seen low, so a level held across reset release never writes
  always_comb begin
    wr_ev = bus.rx_done && armed;
    keep = wr_ev && !(DROP_ERR != 0 && bus.rx_err);
    rd = bus.rd_valid && bus.rd_ready;
    do_wr = keep && (!bus.full || rd);
  end
  assign bus.empty = wr_ptr == rd_ptr;
  assign bus.full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bus.count = wr_ptr - rd_ptr;
  assign bus.rd_valid = !bus.empty;
  assign {bus.rd_err, bus.rd_data} = head;
  assign bus.overflow = ovf;
  assign bus.err_cnt = ecnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      armed <= 1'b0;
      ovf <= 1'b0;
      ecnt <= '0;
    end else begin
      armed <= !bus.rx_done;
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd) rd_ptr <= rd_ptr + (AW+1)'(1);
      ovf <= bus.clr_flags ? 1'b0 : ovf | (keep && bus.full && !rd);
      ecnt <= bus.clr_flags ? '0 : (wr_ev && bus.rx_err) ? sat_inc(ecnt) : ecnt;
    end
  end
  rx_fifo_mem #(.WIDTH(FRAME_WIDTH + 1), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(do_wr),
    .waddr(wr_ptr[AW-1:0]),
    .wdata({bus.rx_err, bus.rx_data}),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(head)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: queue-model scoreboard plus directed literal checks
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  uart_rx_fifo_if #(.FRAME_WIDTH(8), .DEPTH(16)) a ();
  uart_rx_fifo_if #(.FRAME_WIDTH(8), .DEPTH(16)) b ();
  uart_rx_fifo #(.FRAME_WIDTH(8), .DEPTH(16), .DROP_ERR(0)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  uart_rx_fifo #(.FRAME_WIDTH(8), .DEPTH(16), .DROP_ERR(1)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  logic [8:0] mq[$];
  logic m_ovf, m_armed, m_wr, m_rd, m_full;
  int m_ec;
  // model of dut_a: a queue of {err,data}, updated once per rising edge
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_ec = 0;
      m_armed = 1'b0;
    end else begin
      m_wr = a.rx_done && m_armed;
      m_rd = a.rd_ready && mq.size() != 0;
      m_full = mq.size() == 16;
      if (m_rd) void'(mq.pop_front());
      if (m_wr) begin
        if (a.rx_err && m_ec < 255) m_ec++;
        if (!m_full || m_rd) mq.push_back({a.rx_err, a.rx_data});
        else m_ovf = 1'b1;
      end
      if (a.clr_flags) begin
        m_ovf = 1'b0;
        m_ec = 0;
      end
      m_armed = !a.rx_done;
    end
  end
  always @(negedge clk) begin
    check("count", a.count, mq.size());
    check("empty", a.empty, mq.size() == 0);
    check("full", a.full, mq.size() == 16);
    check("rd_valid", a.rd_valid, mq.size() != 0);
    check("overflow", a.overflow, m_ovf);
    check("err_cnt", a.err_cnt, m_ec);
    if (mq.size() != 0) begin
      check("rd_data", a.rd_data, mq[0][7:0]);
      check("rd_err", a.rd_err, mq[0][8]);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic e, input bit ta, input bit tb);
    a.rx_done = ta; a.rx_data = d; a.rx_err = e;
    b.rx_done = tb; b.rx_data = d; b.rx_err = e;
    tick();
    a.rx_done = 1'b0;
    b.rx_done = 1'b0;
    tick();
  endtask
  task automatic drain_a(input int n);
    a.rd_ready = 1'b1;
    repeat (n) tick();
    a.rd_ready = 1'b0;
  endtask
  initial begin
    a.rx_done = 0; a.rx_err = 0; a.rx_data = 0; a.rd_ready = 0; a.clr_flags = 0;
    b.rx_done = 0; b.rx_err = 0; b.rx_data = 0; b.rd_ready = 0; b.clr_flags = 0;
    tick();
    check("reset_empty", a.empty, 1);
    check("reset_err_cnt", a.err_cnt, 0);
    tick();
    rst = 1'b1;
    tick();
    a.rx_done = 1'b1; a.rx_data = 8'hA5;
    tick();
    check("single_valid", a.rd_valid, 1);
    check("single_data", a.rd_data, 8'hA5);
    check("single_count", a.count, 1);
    a.rx_done = 1'b0;
    tick();
    drain_a(1);
    check("single_empty", a.empty, 1);
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1'b1, 1'b0);
    check("fill_full", a.full, 1);
    check("fill_no_ovf", a.overflow, 0);
    send(8'h10, 1'b0, 1'b1, 1'b0);
    check("fill_ovf", a.overflow, 1);
    check("fill_count", a.count, 16);
    a.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("fill_order", a.rd_data, i);
      tick();
    end
    a.rd_ready = 1'b0;
    check("fill_drained", a.empty, 1);
    a.clr_flags = 1'b1;
    tick();
    a.clr_flags = 1'b0;
    check("ovf_cleared", a.overflow, 0);
    for (int i = 0; i < 16; i++) send(8'h40 + 8'(i), 1'b0, 1'b1, 1'b0);
    a.rd_ready = 1'b1; a.rx_done = 1'b1; a.rx_data = 8'h3C;
    tick();
    a.rd_ready = 1'b0; a.rx_done = 1'b0;
    check("fullrw_count", a.count, 16);
    check("fullrw_full", a.full, 1);
    check("fullrw_ovf", a.overflow, 0);
    tick();
    a.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("fullrw_order", a.rd_data, i < 15 ? 32'h41 + i : 32'h3C);
      tick();
    end
    a.rd_ready = 1'b0;
    a.rx_done = 1'b1; a.rx_data = 8'h55;
    repeat (5) tick();
    a.rx_done = 1'b0;
    tick();
    check("held_count", a.count, 1);
    check("held_data", a.rd_data, 8'h55);
    drain_a(1);
    for (int i = 0; i < 3; i++) send(8'h11 + 8'(i), 1'b1, 1'b1, 1'b1);
    check("drop_count", b.count, 0);
    check("drop_empty", b.empty, 1);
    check("drop_err_cnt", b.err_cnt, 3);
    check("keep_count", a.count, 3);
    check("keep_err_cnt", a.err_cnt, 3);
    check("keep_rd_err", a.rd_err, 1);
    a.clr_flags = 1'b1; b.clr_flags = 1'b1;
    tick();
    a.clr_flags = 1'b0; b.clr_flags = 1'b0;
    check("clr_err_a", a.err_cnt, 0);
    check("clr_err_b", b.err_cnt, 0);
    drain_a(3);
    for (int i = 0; i < 256; i++) send(8'h00, 1'b1, 1'b0, 1'b1);
    check("sat_err_cnt", b.err_cnt, 255);
    send(8'h00, 1'b1, 1'b0, 1'b1);
    check("sat_hold", b.err_cnt, 255);
    a.rx_done = 1'b1; a.rx_err = 1'b1; a.rx_data = 8'h99; a.clr_flags = 1'b1;
    tick();
    a.rx_done = 1'b0; a.rx_err = 1'b0; a.clr_flags = 1'b0;
    check("clr_wins", a.err_cnt, 0);
    check("clr_stored", a.rd_data, 8'h99);
    tick();
    drain_a(1);
    for (int i = 0; i < 5; i++) send(8'h20 + 8'(i), 1'b0, 1'b1, 1'b0);
    check("pre_reset_count", a.count, 5);
    #2;
    rst = 1'b0;
    #1;
    check("async_count", a.count, 0);
    check("async_valid", a.rd_valid, 0);
    a.rx_done = 1'b1; a.rx_data = 8'h77;
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("held_at_release", a.count, 0);
    a.rx_done = 1'b0;
    tick();
    a.rx_done = 1'b1;
    tick();
    a.rx_done = 1'b0;
    check("post_reset_count", a.count, 1);
    check("post_reset_data", a.rd_data, 8'h77);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
